alloc_gen: RTL and testbench

Parametrised successor to the linked-memory heap allocator. Manages a LIFO free-list threaded through BRAM, plus a bump pointer for never-used cells. Adds:
- asynchronous reset
- allocation-valid and error strobes
- explicit port-collision handling
- live-cell count
- configurable address tag

Sits between the actor/cons-cell engine and BRAM as the sole owner of heap memory.

---
 rtl/alloc_gen.sv | 179 +++++++++++++++++
 tb/tb_alloc_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alloc_gen.sv
// alloc_gen: sole owner of heap BRAM; LIFO free-list threaded through memory plus a bump pointer.
// Optional macro ALLOC_STATS_EN adds o_peak, the high-water mark of o_count since reset.
module alloc_gen #(
    parameter int                 DATA_SZ  = 16,
    parameter int                 ADDR_SZ  = 8,
    parameter int                 MEM_MAX  = (1 << ADDR_SZ),
    parameter logic [DATA_SZ-1:0] ADDR_TAG = 16'h5000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_al,
    input  logic [DATA_SZ-1:0] i_adata,
    output logic [DATA_SZ-1:0] o_aaddr,
    output logic               o_aval,
    input  logic               i_fr,
    input  logic [DATA_SZ-1:0] i_faddr,
    input  logic               i_wr,
    input  logic [DATA_SZ-1:0] i_waddr,
    input  logic [DATA_SZ-1:0] i_wdata,
    input  logic               i_rd,
    input  logic [DATA_SZ-1:0] i_raddr,
    output logic [DATA_SZ-1:0] o_rdata,
    output logic               o_err,
    output logic               o_full,
    output logic [ADDR_SZ:0]   o_count
`ifdef ALLOC_STATS_EN
    ,
    output logic [ADDR_SZ:0]   o_peak
`endif
);

    localparam int            CW      = ADDR_SZ + 1;
    localparam int            DEPTH   = 1 << ADDR_SZ;
    localparam logic [CW-1:0] TOP_MAX = CW'(MEM_MAX);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [DATA_SZ-1:0] mem_q [0:DEPTH-1];
    logic [DATA_SZ-1:0] rdata_q;

    logic [CW-1:0]      top_q, top_d, count_q, count_d;
    logic [ADDR_SZ-1:0] head_q, head_d;
    logic               hvld_q, hvld_d, pend_q, pend_d;
    logic [DATA_SZ-1:0] aaddr_q, aaddr_d;
    logic               aval_q, aval_d, err_q, err_d;

    logic [ADDR_SZ-1:0] head_s, raddr_s, waddr_s;
    logic               hvld_s, full_s, we_s, unused_s;
    logic [DATA_SZ-1:0] wdata_s, link_s;

    // A pop leaves the next link in the BRAM output register; use it until it is latched.
    assign head_s = pend_q ? rdata_q[ADDR_SZ-1:0] : head_q;
    assign hvld_s = pend_q ? rdata_q[DATA_SZ-1]   : hvld_q;
    assign full_s = !hvld_s && (top_q == TOP_MAX);

    always_comb begin
        link_s              = '0;
        link_s[DATA_SZ-1]   = hvld_s;
        link_s[ADDR_SZ-1:0] = head_s;
    end

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        head_d  = head_s;
        hvld_d  = hvld_s;
        pend_d  = 1'b0;
        aaddr_d = '0;
        aval_d  = 1'b0;
        err_d   = 1'b0;
        we_s    = 1'b0;
        waddr_s = i_waddr[ADDR_SZ-1:0];
        wdata_s = i_wdata;
        raddr_s = i_raddr[ADDR_SZ-1:0];
        if (i_wr && (i_al || i_fr)) begin
            // write port already taken by the user write, which still proceeds
            err_d = 1'b1;
            we_s  = 1'b1;
        end else if (i_al && i_fr) begin
            we_s    = 1'b1;
            waddr_s = i_faddr[ADDR_SZ-1:0];
            wdata_s = i_adata;
            aval_d  = 1'b1;
            aaddr_d = ADDR_TAG | DATA_SZ'(i_faddr[ADDR_SZ-1:0]);
        end else if (i_al) begin
            if (hvld_s) begin
                if (i_rd) begin
                    err_d = 1'b1;
                end else begin
                    raddr_s = head_s;
                    pend_d  = 1'b1;
                    we_s    = 1'b1;
                    waddr_s = head_s;
                    wdata_s = i_adata;
                    aval_d  = 1'b1;
                    aaddr_d = ADDR_TAG | DATA_SZ'(head_s);
                    count_d = count_q + ONE;
                end
            end else if (top_q < TOP_MAX) begin
                we_s    = 1'b1;
                waddr_s = top_q[ADDR_SZ-1:0];
                wdata_s = i_adata;
                aval_d  = 1'b1;
                aaddr_d = ADDR_TAG | DATA_SZ'(top_q[ADDR_SZ-1:0]);
                top_d   = top_q + ONE;
                count_d = count_q + ONE;
            end else begin
                err_d = 1'b1;
            end
        end else if (i_fr) begin
            we_s    = 1'b1;
            waddr_s = i_faddr[ADDR_SZ-1:0];
            wdata_s = link_s;
            head_d  = i_faddr[ADDR_SZ-1:0];
            hvld_d  = 1'b1;
            count_d = count_q - ONE;
        end else if (i_wr) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Read-first BRAM: a pop reads the old link while overwriting the cell with i_adata.
    always_ff @(posedge i_clk) begin
        rdata_q <= mem_q[raddr_s];
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            top_q   <= '0;
            count_q <= '0;
            head_q  <= '0;
            hvld_q  <= 1'b0;
            pend_q  <= 1'b0;
            aaddr_q <= '0;
            aval_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            head_q  <= head_d;
            hvld_q  <= hvld_d;
            pend_q  <= pend_d;
            aaddr_q <= aaddr_d;
            aval_q  <= aval_d;
            err_q   <= err_d;
        end
    end

`ifdef ALLOC_STATS_EN
    logic [CW-1:0] peak_q, peak_d;

    assign peak_d = (count_d > peak_q) ? count_d : peak_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign o_peak = peak_q;
`endif

    assign unused_s = ^{i_faddr[DATA_SZ-1:ADDR_SZ], i_waddr[DATA_SZ-1:ADDR_SZ],
                        i_raddr[DATA_SZ-1:ADDR_SZ]};

    assign o_aaddr = aaddr_q;
    assign o_aval  = aval_q;
    assign o_err   = err_q;
    assign o_rdata = rdata_q;
    assign o_full  = full_s;
    assign o_count = count_q;

endmodule

// File: tb/tb_alloc_gen.sv
// Scoreboard bench for alloc_gen (4-cell heap): directed scenarios plus randomized traffic
// against a queue-based reference model of the free-list, bump pointer and memory.
module tb_alloc_gen;
    localparam int          AW  = 2;
    localparam int          MM  = 4;
    localparam logic [15:0] TAG = 16'h5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        al, fr, wr, rd;
    logic [15:0] adata, faddr, waddr, wdata, raddr;
    logic [15:0] aaddr, rdata;
    logic        aval, err, full;
    logic [AW:0] count;
`ifdef ALLOC_STATS_EN
    logic [AW:0] peak_o;
`endif

    alloc_gen #(.DATA_SZ(16), .ADDR_SZ(AW), .MEM_MAX(MM), .ADDR_TAG(TAG)) dut (
        .i_clk(clk), .i_rst(rst), .i_al(al), .i_adata(adata), .o_aaddr(aaddr), .o_aval(aval),
        .i_fr(fr), .i_faddr(faddr), .i_wr(wr), .i_waddr(waddr), .i_wdata(wdata),
        .i_rd(rd), .i_raddr(raddr), .o_rdata(rdata), .o_err(err), .o_full(full),
        .o_count(count)
`ifdef ALLOC_STATS_EN
        , .o_peak(peak_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          aval;
        bit          err;
        logic [15:0] aaddr;
        bit          rchk;
        logic [15:0] rdata;
        int          count;
        bit          full;
        int          peak;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // reference model state
    int          fstack[$];
    int          live[$];
    int          top, cnt, peak;
    logic [15:0] mm [0:MM-1];
    bit          known [0:MM-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fstack.delete();
        live.delete();
        top  = 0;
        cnt  = 0;
        peak = 0;
    endtask

    task automatic clr_inputs();
        al = 1'b0; fr = 1'b0; wr = 1'b0; rd = 1'b0;
        adata = 16'h0; faddr = 16'h0; waddr = 16'h0; wdata = 16'h0; raddr = 16'h0;
    endtask

    task automatic issue(input bit al_v, input bit fr_v, input bit wr_v, input bit rd_v,
                         input logic [15:0] ad, input logic [15:0] fa, input logic [15:0] wa,
                         input logic [15:0] wd, input logic [15:0] ra);
        exp_t e;
        int   fp, wp, rp, wr_at, a_i;
        @(posedge clk);
        #1;
        al = al_v; fr = fr_v; wr = wr_v; rd = rd_v;
        adata = ad; faddr = fa; waddr = wa; wdata = wd; raddr = ra;
        fp = int'(fa[AW-1:0]);
        wp = int'(wa[AW-1:0]);
        rp = int'(ra[AW-1:0]);
        wr_at = -1;
        a_i = -1;
        e.cyc = cyc; e.aval = 1'b0; e.err = 1'b0; e.aaddr = 16'h0;
        e.rchk = 1'b0; e.rdata = 16'h0;
        if (rd_v) begin
            e.rchk  = known[rp];
            e.rdata = mm[rp];
        end
        if (wr_v && (al_v || fr_v)) begin
            e.err = 1'b1;
            mm[wp] = wd; known[wp] = 1'b1; wr_at = wp;
        end else if (al_v && fr_v) begin
            e.aval = 1'b1; e.aaddr = TAG | 16'(fp);
            mm[fp] = ad; known[fp] = 1'b1; wr_at = fp;
        end else if (al_v) begin
            if (fstack.size() > 0) begin
                if (rd_v) e.err = 1'b1;
                else a_i = fstack.pop_back();
            end else if (top < MM) begin
                a_i = top;
                top++;
            end else begin
                e.err = 1'b1;
            end
            if (a_i >= 0) begin
                live.push_back(a_i);
                cnt++;
                e.aval = 1'b1; e.aaddr = TAG | 16'(a_i);
                mm[a_i] = ad; known[a_i] = 1'b1; wr_at = a_i;
            end
        end else if (fr_v) begin
            fstack.push_back(fp);
            for (int i = 0; i < live.size(); i++) begin
                if (live[i] == fp) begin
                    live.delete(i);
                    break;
                end
            end
            cnt--;
            known[fp] = 1'b0; wr_at = fp;
        end else if (wr_v) begin
            mm[wp] = wd; known[wp] = 1'b1; wr_at = wp;
        end
        if (rd_v && wr_at == rp) e.rchk = 1'b0;
        if (cnt > peak) peak = cnt;
        e.count = cnt;
        e.full  = (fstack.size() == 0) && (top == MM);
        e.peak  = peak;
        sbq.push_back(e);
    endtask

    task automatic alloc(input logic [15:0] d);
        issue(1'b1, 1'b0, 1'b0, 1'b0, d, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic free(input logic [15:0] a);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, a, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic read(input logic [15:0] a);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, a);
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    // Let the last request retire and stop at the next negedge for direct checks.
    task automatic settle();
        idle();
        @(negedge clk);
    endtask

    // Monitor: retires one expected record per DUT cycle and compares every output.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                chk("aval", 32'(aval), 32'(e.aval));
                chk("err", 32'(err), 32'(e.err));
                chk("aaddr", 32'(aaddr), 32'(e.aaddr));
                chk("count", 32'(count), 32'(e.count));
                chk("full", 32'(full), 32'(e.full));
                if (e.rchk) chk("rdata", 32'(rdata), 32'(e.rdata));
`ifdef ALLOC_STATS_EN
                chk("peak", 32'(peak_o), 32'(e.peak));
`endif
            end else if (aval || err) begin
                chk("spurious_strobe", {30'h0, aval, err}, 32'h0);
            end
        end
    end

    initial begin
        for (int i = 0; i < MM; i++) known[i] = 1'b0;
        clr_inputs();
        model_reset();
        rst = 1'b1;
        #12;
        chk("rst_aval", 32'(aval), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_aaddr", 32'(aaddr), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        alloc(16'h0011); alloc(16'h0022); alloc(16'h0033); alloc(16'h0044);
        alloc(16'h0055);
        settle();
        chk("full_count", 32'(count), 32'h4);
        chk("full_flag", 32'(full), 32'h1);

        free(16'h5001); free(16'h5003);
        alloc(16'h0055); alloc(16'h0066);
        read(16'h5001);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h0077, 16'h5002, 16'h0, 16'h0, 16'h0);
        read(16'h5002);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h00AA, 16'h0, 16'h5000, 16'h0099, 16'h0);
        read(16'h5000);
        free(16'h5001);
        issue(1'b1, 1'b0, 1'b0, 1'b1, 16'h00BB, 16'h0, 16'h0, 16'h0, 16'h5000);

        // reset between edges while an alloc result is on the outputs
        alloc(16'h00CC);
        @(posedge clk);
        #1;
        chk("pre_rst_aval", 32'(aval), 32'h1);
        #1;
        rst = 1'b1;
        clr_inputs();
        sbq.delete();
        model_reset();
        #1;
        chk("midrst_aval", 32'(aval), 32'h0);
        chk("midrst_aaddr", 32'(aaddr), 32'h0);
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_full", 32'(full), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        alloc(16'h00DD);
        settle();
        chk("post_rst_count", 32'(count), 32'h1);

        alloc(16'h00E1); alloc(16'h00E2);
        free(16'h5001); free(16'h5002);
        alloc(16'h00E3);
        settle();
        chk("stats_count", 32'(count), 32'h2);
`ifdef ALLOC_STATS_EN
        chk("stats_peak", 32'(peak_o), 32'h3);
`endif

        for (int n = 0; n < 300; n++) begin
            bit          a, f, w, r;
            int          li;
            logic [15:0] fa, wa, ra;
            a = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 2) == 0);
            f = 1'b0; w = 1'b0; fa = TAG; wa = TAG;
            if (live.size() > 0) begin
                f  = ($urandom_range(0, 2) == 0);
                w  = ($urandom_range(0, 4) == 0);
                li = int'($urandom_range(0, live.size() - 1));
                fa = TAG | 16'(live[li]);
                li = int'($urandom_range(0, live.size() - 1));
                wa = TAG | 16'(live[li]);
            end
            ra = TAG | 16'($urandom_range(0, MM - 1));
            issue(a, f, w, r, 16'($urandom), fa, wa, 16'($urandom), ra);
        end

        idle(); idle();
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        chk("drain_left", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
